// File: rtl/decode_pkg.sv
// Shared state, ALU and Funct encodings for the multicycle decode controller.
// DECODE_FP_EN adds the floating-point long-op codes to the Funct decoder.
package decode_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, LONGWAIT, WB2, BRANCH
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_ORR  = 4'd3;
  localparam logic [3:0] ALU_MUL  = 4'd4;
  localparam logic [3:0] ALU_UMUL = 4'd5;
  localparam logic [3:0] ALU_SMUL = 4'd6;
  localparam logic [3:0] ALU_DIV  = 4'd7;
  localparam logic [3:0] ALU_MOV  = 4'd8;

  localparam logic [3:0] FN_ADD  = 4'b0100;
  localparam logic [3:0] FN_SUB  = 4'b0010;
  localparam logic [3:0] FN_AND  = 4'b0000;
  localparam logic [3:0] FN_ORR  = 4'b1100;
  localparam logic [3:0] FN_MUL  = 4'b0001;
  localparam logic [3:0] FN_UMUL = 4'b1001;
  localparam logic [3:0] FN_SMUL = 4'b1010;
  localparam logic [3:0] FN_DIV  = 4'b1000;
  localparam logic [3:0] FN_MOV  = 4'b1101;

`ifdef DECODE_FP_EN
  localparam logic [3:0] ALU_FADD = 4'd9;
  localparam logic [3:0] ALU_FMUL = 4'd10;
  localparam logic [3:0] FN_FADD  = 4'b1110;
  localparam logic [3:0] FN_FMUL  = 4'b1111;
  localparam logic [3:0] FN_FADDH = 4'b0110;
  localparam logic [3:0] FN_FMULH = 4'b0111;
`endif

  typedef struct packed {
    logic       valid;
    logic       is_long;
    logic       is_dual;
    logic       is_addsub;
`ifdef DECODE_FP_EN
    logic       half;
`endif
    logic [3:0] alu;
  } op_dec_t;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       regw2;
    logic       memw;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic       branch;
    logic       alu_en;
    logic       flag_en;
  } ctl_t;

  // Dual-result ops (umul/smul) need a second write-back cycle after ALUWB.
  function automatic op_dec_t decode_funct(input logic [3:0] fn);
    op_dec_t d;
    d = '0;
    d.valid = 1'b1;
    case (fn)
      FN_ADD:  begin d.alu = ALU_ADD; d.is_addsub = 1'b1; end
      FN_SUB:  begin d.alu = ALU_SUB; d.is_addsub = 1'b1; end
      FN_AND:  d.alu = ALU_AND;
      FN_ORR:  d.alu = ALU_ORR;
      FN_MOV:  d.alu = ALU_MOV;
      FN_MUL:  begin d.alu = ALU_MUL; d.is_long = 1'b1; end
      FN_UMUL: begin d.alu = ALU_UMUL; d.is_long = 1'b1; d.is_dual = 1'b1; end
      FN_SMUL: begin d.alu = ALU_SMUL; d.is_long = 1'b1; d.is_dual = 1'b1; end
      FN_DIV:  begin d.alu = ALU_DIV; d.is_long = 1'b1; end
`ifdef DECODE_FP_EN
      FN_FADD:  begin d.alu = ALU_FADD; d.is_long = 1'b1; end
      FN_FMUL:  begin d.alu = ALU_FMUL; d.is_long = 1'b1; end
      FN_FADDH: begin d.alu = ALU_FADD; d.is_long = 1'b1; d.half = 1'b1; end
      FN_FMULH: begin d.alu = ALU_FMUL; d.is_long = 1'b1; d.half = 1'b1; end
`endif
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// Instruction-field inputs and control outputs of decode_ctrl, bundled with master/slave views.
interface decode_ctrl_if #(parameter int ALUCW = 4);

  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       Rd;
  logic             LongDone;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             NextPC;
  logic             RegW;
  logic             RegW2;
  logic             MemW;
  logic             IRWrite;
  logic             AdrSrc;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [1:0]       RegSrc;
  logic [ALUCW-1:0] ALUControl;
  logic             LongStart;
  logic             Half;
  logic             Fault;

  modport master (
    output Op, Funct, Rd, LongDone,
    input  FlagW, PCS, NextPC, RegW, RegW2, MemW, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl,
           LongStart, Half, Fault
  );

  modport slave (
    input  Op, Funct, Rd, LongDone,
    output FlagW, PCS, NextPC, RegW, RegW2, MemW, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl,
           LongStart, Half, Fault
  );

endinterface

// File: rtl/decode_fsm.sv
// Multicycle sequencing FSM with the long-op timeout counter; LongStart and Fault are
// registered so each shows up as a clean one-cycle pulse in the state that follows the decision.
module decode_fsm
  import decode_pkg::*;
#(
  parameter int LONG_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic       funct_imm,
  input  logic       funct_load,
  input  logic       dec_valid,
  input  logic       dec_long,
  input  logic       dual_q,
  input  logic       long_done,
  output state_t     state,
  output ctl_t       ctl,
  output logic       long_start,
  output logic       fault
);

  localparam int CW = (LONG_TIMEOUT > 1) ? $clog2(LONG_TIMEOUT) : 1;

  state_t        state_n;
  logic [CW-1:0] wait_cnt;
  logic          timeout;
  logic          start_n;
  logic          fault_n;

  assign timeout = (wait_cnt == CW'(LONG_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      long_start <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      long_start <= start_n;
      fault      <= fault_n;
      if (state == LONGWAIT && state_n == LONGWAIT) wait_cnt <= wait_cnt + CW'(1);
      else                                          wait_cnt <= '0;
    end
  end

  always_comb begin
    state_n = state;
    ctl     = '0;
    start_n = 1'b0;
    fault_n = 1'b0;
    case (state)
      FETCH: begin
        ctl.irwrite   = 1'b1;
        ctl.nextpc    = 1'b1;
        ctl.alusrca   = 2'b01;
        ctl.alusrcb   = 2'b10;
        ctl.resultsrc = 2'b10;
        state_n       = DECODE;
      end
      DECODE: begin
        ctl.alusrca   = 2'b01;
        ctl.alusrcb   = 2'b10;
        ctl.resultsrc = 2'b10;
        case (op)
          2'b01: state_n = MEMADR;
          2'b10: state_n = BRANCH;
          2'b00: begin
            if (!dec_valid) begin
              state_n = FETCH;
              fault_n = 1'b1;
            end else if (dec_long) begin
              state_n = LONGWAIT;
              start_n = 1'b1;
            end else begin
              state_n = funct_imm ? EXECI : EXECR;
            end
          end
          default: begin
            state_n = FETCH;
            fault_n = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ctl.alusrcb = 2'b01;
        state_n     = funct_load ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctl.adrsrc = 1'b1;
        state_n    = MEMWB;
      end
      MEMWB: begin
        ctl.resultsrc = 2'b01;
        ctl.regw      = 1'b1;
        state_n       = FETCH;
      end
      MEMWR: begin
        ctl.adrsrc = 1'b1;
        ctl.memw   = 1'b1;
        state_n    = FETCH;
      end
      EXECR: begin
        ctl.alu_en  = 1'b1;
        ctl.flag_en = 1'b1;
        state_n     = ALUWB;
      end
      EXECI: begin
        ctl.alusrcb = 2'b01;
        ctl.alu_en  = 1'b1;
        ctl.flag_en = 1'b1;
        state_n     = ALUWB;
      end
      // A completion arriving on the timeout cycle still wins over the abort.
      LONGWAIT: begin
        ctl.alu_en = 1'b1;
        if (long_done) begin
          ctl.flag_en = 1'b1;
          state_n     = ALUWB;
        end else if (timeout) begin
          state_n = FETCH;
          fault_n = 1'b1;
        end
      end
      ALUWB: begin
        ctl.regw = 1'b1;
        state_n  = dual_q ? WB2 : FETCH;
      end
      WB2: begin
        ctl.regw2 = 1'b1;
        state_n   = FETCH;
      end
      BRANCH: begin
        ctl.alusrcb   = 2'b01;
        ctl.resultsrc = 2'b10;
        ctl.branch    = 1'b1;
        state_n       = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Top of the decode controller: Funct/ALU decode, flag and PC-write logic around decode_fsm.
// Define DECODE_FP_EN to accept fadd/fmul/faddh/fmulh as long-ops and drive Half.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int ALUCW        = 4,
  parameter int LONG_TIMEOUT = 64
) (
  input logic          clk,
  input logic          reset,
  decode_ctrl_if.slave bus
);

  state_t     state;
  ctl_t       ctl;
  op_dec_t    dec;
  logic [3:0] alu_q;
  logic       dual_q;
  logic       addsub_q;
  logic       s_q;

  assign dec = decode_funct(bus.Funct[4:1]);

  // Capture the decoded op once so ALUControl stays steady for the whole long-op wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q    <= '0;
      dual_q   <= 1'b0;
      addsub_q <= 1'b0;
      s_q      <= 1'b0;
    end else if (state == DECODE) begin
      alu_q    <= dec.alu;
      dual_q   <= dec.is_dual;
      addsub_q <= dec.is_addsub;
      s_q      <= bus.Funct[0];
    end
  end

`ifdef DECODE_FP_EN
  logic half_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  half_q <= 1'b0;
    else if (state == DECODE)   half_q <= dec.half;
  end

  assign bus.Half = ctl.alu_en & half_q;
`else
  assign bus.Half = 1'b0;
`endif

  decode_fsm #(
    .LONG_TIMEOUT (LONG_TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .op         (bus.Op),
    .funct_imm  (bus.Funct[5]),
    .funct_load (bus.Funct[0]),
    .dec_valid  (dec.valid),
    .dec_long   (dec.is_long),
    .dual_q     (dual_q),
    .long_done  (bus.LongDone),
    .state      (state),
    .ctl        (ctl),
    .long_start (bus.LongStart),
    .fault      (bus.Fault)
  );

  assign bus.IRWrite    = ctl.irwrite;
  assign bus.NextPC     = ctl.nextpc;
  assign bus.RegW       = ctl.regw;
  assign bus.RegW2      = ctl.regw2;
  assign bus.MemW       = ctl.memw;
  assign bus.AdrSrc     = ctl.adrsrc;
  assign bus.ResultSrc  = ctl.resultsrc;
  assign bus.ALUSrcA    = ctl.alusrca;
  assign bus.ALUSrcB    = ctl.alusrcb;
  assign bus.ALUControl = ctl.alu_en ? ALUCW'(alu_q) : '0;
  assign bus.FlagW      = ctl.flag_en ? {s_q, s_q & addsub_q} : 2'b00;
  assign bus.PCS        = ((bus.Rd == 4'b1111) & ctl.regw) | ctl.branch;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: directed instruction table, reset-in-LONGWAIT sequence and random
// instructions, all compared cycle by cycle with a per-instruction timeline model.
module tb_decode_ctrl;

  localparam int TIMEOUT = 64;
  localparam int NV      = 12;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs;
    logic       nextpc;
    logic       regw;
    logic       regw2;
    logic       memw;
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic       longstart;
    logic       half;
    logic       fault;
  } outs_t;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         lat;
    int         exp_aluc;
    int         exp_writes;
    bit         exp_fault;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  decode_ctrl_if #(.ALUCW(4)) bus ();

  decode_ctrl #(
    .ALUCW        (4),
    .LONG_TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  outs_t exp_q[$];
  bit    done_q[$];
  bit    pending_fault = 1'b0;
  int    obs_aluc;
  int    obs_writes;
  bit    obs_fault;
  vec_t  tab[NV];
  logic [1:0] r_op;
  logic [5:0] r_funct;
  logic [3:0] r_rd;
  int         r_sel;
  int         r_lat;

  function automatic int alu_code(input logic [3:0] fn);
    int r;
    case (fn)
      4'b0100: r = 0;
      4'b0010: r = 1;
      4'b0000: r = 2;
      4'b1100: r = 3;
      4'b0001: r = 4;
      4'b1001: r = 5;
      4'b1010: r = 6;
      4'b1000: r = 7;
      4'b1101: r = 8;
`ifdef DECODE_FP_EN
      4'b1110, 4'b0110: r = 9;
      4'b1111, 4'b0111: r = 10;
`endif
      default: r = -1;
    endcase
    return r;
  endfunction

  function automatic outs_t fetch_outs(input bit f);
    outs_t e;
    e = '0;
    e.irwrite   = 1'b1;
    e.nextpc    = 1'b1;
    e.alusrca   = 2'b01;
    e.alusrcb   = 2'b10;
    e.resultsrc = 2'b10;
    e.fault     = f;
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t s;
    s.flagw     = bus.FlagW;
    s.pcs       = bus.PCS;
    s.nextpc    = bus.NextPC;
    s.regw      = bus.RegW;
    s.regw2     = bus.RegW2;
    s.memw      = bus.MemW;
    s.irwrite   = bus.IRWrite;
    s.adrsrc    = bus.AdrSrc;
    s.resultsrc = bus.ResultSrc;
    s.alusrca   = bus.ALUSrcA;
    s.alusrcb   = bus.ALUSrcB;
    s.aluc      = bus.ALUControl;
    s.longstart = bus.LongStart;
    s.half      = bus.Half;
    s.fault     = bus.Fault;
    return s;
  endfunction

  function automatic vec_t mk(input string n, input logic [1:0] op, input logic [5:0] f,
                              input logic [3:0] rd, input int lat, input int aluc,
                              input int wr, input bit flt);
    vec_t v;
    v.name = n; v.op = op; v.funct = f; v.rd = rd; v.lat = lat;
    v.exp_aluc = aluc; v.exp_writes = wr; v.exp_fault = flt;
    return v;
  endfunction

  task automatic add_cycle(input outs_t e, input bit d);
    exp_q.push_back(e);
    done_q.push_back(d);
  endtask

  // Expected per-cycle outputs for one instruction, FETCH first; lat is the LONGWAIT
  // cycle (1-based) carrying LongDone, 0 meaning it never arrives.
  task automatic build_timeline(input logic [1:0] op, input logic [5:0] funct,
                                input logic [3:0] rd, input int lat);
    outs_t e;
    int    code = alu_code(funct[4:1]);
    bit    is_long = (code >= 4 && code <= 7) || code >= 9;
    bit    half = 1'b0;
`ifdef DECODE_FP_EN
    half = (funct[4:1] == 4'b0110) || (funct[4:1] == 4'b0111);
`endif
    exp_q.delete();
    done_q.delete();
    add_cycle(fetch_outs(pending_fault), 1'b0);
    e = fetch_outs(1'b0);
    e.irwrite = 1'b0;
    e.nextpc  = 1'b0;
    add_cycle(e, 1'b0);
    pending_fault = 1'b0;
    if (op == 2'b01) begin
      e = '0; e.alusrcb = 2'b01; add_cycle(e, 1'b0);
      if (funct[0]) begin
        e = '0; e.adrsrc = 1'b1; add_cycle(e, 1'b0);
        e = '0; e.resultsrc = 2'b01; e.regw = 1'b1; e.pcs = (rd == 4'hF); add_cycle(e, 1'b0);
      end else begin
        e = '0; e.adrsrc = 1'b1; e.memw = 1'b1; add_cycle(e, 1'b0);
      end
    end else if (op == 2'b10) begin
      e = '0; e.alusrcb = 2'b01; e.resultsrc = 2'b10; e.pcs = 1'b1; add_cycle(e, 1'b0);
    end else if (op == 2'b11 || code < 0) begin
      pending_fault = 1'b1;
    end else begin
      if (!is_long) begin
        e = '0;
        e.alusrcb = funct[5] ? 2'b01 : 2'b00;
        e.aluc    = code[3:0];
        e.flagw   = {funct[0], funct[0] && code <= 1};
        add_cycle(e, 1'b0);
      end else begin
        for (int k = 1; k <= TIMEOUT; k++) begin
          e = '0;
          e.aluc      = code[3:0];
          e.half      = half;
          e.longstart = (k == 1);
          if (k == lat) begin
            e.flagw = {funct[0], funct[0] && code <= 1};
            add_cycle(e, 1'b1);
            break;
          end
          add_cycle(e, 1'b0);
        end
      end
      if (!is_long || (lat >= 1 && lat <= TIMEOUT)) begin
        e = '0; e.regw = 1'b1; e.pcs = (rd == 4'hF); add_cycle(e, 1'b0);
        if (code == 5 || code == 6) begin
          e = '0; e.regw2 = 1'b1; add_cycle(e, 1'b0);
        end
      end else begin
        pending_fault = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input outs_t exp, input logic [1:0] op);
    outs_t      got;
    logic [1:0] exp_regsrc;
    got        = sample();
    exp_regsrc = {op == 2'b01, op == 2'b10};
    checks++;
    if (got !== exp || bus.ImmSrc !== op || bus.RegSrc !== exp_regsrc) begin
      errors++;
      $display("[TB] FAIL %s: got outs=%h imm=%b regsrc=%b, expected outs=%h imm=%b regsrc=%b",
               name, got, bus.ImmSrc, bus.RegSrc, exp, op, exp_regsrc);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Entered just after a posedge in a FETCH cycle; returns just after the posedge that
  // starts the next FETCH.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] rd, input int lat);
    build_timeline(op, funct, rd, lat);
    obs_aluc   = 0;
    obs_writes = 0;
    bus.Op     = op;
    bus.Funct  = funct;
    bus.Rd     = rd;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.LongDone = done_q[i];
      @(negedge clk);
      if (i == 0) obs_fault = bus.Fault;
      obs_aluc   = obs_aluc | int'(bus.ALUControl);
      obs_writes = obs_writes + int'(bus.RegW) + int'(bus.RegW2);
      checkOutput($sformatf("%s c%0d", name, i), exp_q[i], op);
      @(posedge clk);
      #1;
    end
    bus.LongDone = 1'b0;
  endtask

  task automatic reset_in_longwait();
    outs_t e;
    bus.Op       = 2'b00;
    bus.Funct    = 6'b010000;
    bus.Rd       = 4'd4;
    bus.LongDone = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = '0; e.aluc = 4'd7; e.longstart = 1'b1;
    checkOutput("rst_lw_start", e, 2'b00);
    repeat (2) begin @(posedge clk); #1; end
    e.longstart = 1'b0;
    checkOutput("rst_lw_hold", e, 2'b00);
    #2 reset = 1'b1;
    #1 checkOutput("rst_lw_async", fetch_outs(1'b0), 2'b00);
    @(posedge clk); #1;
    checkOutput("rst_lw_held", fetch_outs(1'b0), 2'b00);
    reset = 1'b0;
    pending_fault = 1'b0;
  endtask

  initial begin
    tab[0]  = mk("add_imm",     2'b00, 6'b101000, 4'd3,  0,  0, 1, 1'b0);
    tab[1]  = mk("ldr_pc",      2'b01, 6'b000001, 4'd15, 0,  0, 1, 1'b0);
    tab[2]  = mk("str",         2'b01, 6'b000000, 4'd2,  0,  0, 0, 1'b0);
    tab[3]  = mk("sub_reg_s",   2'b00, 6'b000101, 4'd1,  0,  1, 1, 1'b0);
    tab[4]  = mk("orr_imm_s",   2'b00, 6'b111001, 4'd6,  0,  3, 1, 1'b0);
    tab[5]  = mk("umul_s",      2'b00, 6'b010011, 4'd7,  5,  5, 2, 1'b0);
    tab[6]  = mk("div_timeout", 2'b00, 6'b010000, 4'd5,  0,  7, 0, 1'b1);
    tab[7]  = mk("div_done64",  2'b00, 6'b010000, 4'd5,  64, 7, 1, 1'b0);
    tab[8]  = mk("branch",      2'b10, 6'b000000, 4'd0,  0,  0, 0, 1'b0);
    tab[9]  = mk("op11",        2'b11, 6'b000000, 4'd0,  0,  0, 0, 1'b1);
`ifdef DECODE_FP_EN
    tab[10] = mk("faddh",       2'b00, 6'b001100, 4'd9,  3,  9, 1, 1'b0);
`else
    tab[10] = mk("faddh",       2'b00, 6'b001100, 4'd9,  3,  0, 0, 1'b1);
`endif
    tab[11] = mk("mov_pc",      2'b00, 6'b111010, 4'd15, 0,  8, 1, 1'b0);

    bus.Op = 2'b00; bus.Funct = 6'b000000; bus.Rd = 4'd0; bus.LongDone = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkOutput("reset", fetch_outs(1'b0), 2'b00);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(tab[i].name, tab[i].op, tab[i].funct, tab[i].rd, tab[i].lat);
      if (i > 0) check_val({tab[i-1].name, " fault"}, int'(obs_fault), int'(tab[i-1].exp_fault));
      check_val({tab[i].name, " aluc"}, obs_aluc, tab[i].exp_aluc);
      check_val({tab[i].name, " writes"}, obs_writes, tab[i].exp_writes);
    end
    applyStimulus("tail", 2'b10, 6'b000000, 4'd0, 0);
    check_val({tab[NV-1].name, " fault"}, int'(obs_fault), int'(tab[NV-1].exp_fault));

    reset_in_longwait();
    applyStimulus("umul_after_rst", 2'b00, 6'b010010, 4'd2, 2);
    check_val("umul_after_rst writes", obs_writes, 2);

    for (int n = 0; n < 150; n++) begin
      r_sel   = int'($urandom_range(0, 9));
      r_op    = (r_sel < 6) ? 2'b00 : (r_sel < 8) ? 2'b01 : (r_sel < 9) ? 2'b10 : 2'b11;
      r_funct = 6'($urandom());
      r_rd    = 4'($urandom());
      r_sel   = int'($urandom_range(0, 19));
      r_lat   = (r_sel == 0) ? 0 : (r_sel == 1) ? TIMEOUT : int'($urandom_range(1, 10));
      applyStimulus($sformatf("rnd%0d", n), r_op, r_funct, r_rd, r_lat);
    end
    applyStimulus("rnd_tail", 2'b10, 6'b000000, 4'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter ALUCW, default 4, ALUControl width (>=4; upper bits zero-filled).
REQ-002 SHALL have parameter LONG_TIMEOUT, default 64, max cycles spent in LONGWAIT before abort.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Op  in  2  instruction class.
- Funct  in  6  instruction function field.
- Rd  in  4  destination register.
- LongDone  in  1  long-op unit completion.
- FlagW  out  2  flag-write enables {NZ, CV}.
- PCS  out  1  PC write.
- NextPC  out  1  PC+4 update.
- RegW, RegW2  out  1  register write, second-result write.
- MemW  out  1  memory write.
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  address select.
- ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc  out  2  datapath selects.
- ALUControl  out  ALUCW  ALU operation.
- LongStart  out  1  one-cycle long-op start pulse.
- Half  out  1  half-precision mode.
- Fault  out  1  one-cycle pulse on undefined op or timeout.

Function
REQ-004 SHALL implement Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, LONGWAIT, WB2, BRANCH.
REQ-005 SHALL transition: FETCH->DECODE; DECODE: Op=01->MEMADR, Op=10->BRANCH, Op=00 long-op->LONGWAIT, Op=00 Funct[5]=1->EXECI, Op=00 Funct[5]=0->EXECR, Op=11 or undefined Funct->FETCH with Fault; MEMADR: Funct[0]=1->MEMRD else MEMWR; MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, WB2, BRANCH->FETCH.
REQ-006 SHALL drive per state (unlisted outputs 0): FETCH IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; DECODE ALUSrcA=01, ALUSrcB=10, ResultSrc=10; MEMADR ALUSrcB=01; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegW=1; MEMWR AdrSrc=1, MemW=1; EXECR ALUSrcB=00; EXECI ALUSrcB=01; ALUWB RegW=1; WB2 RegW2=1; BRANCH ALUSrcB=01, ResultSrc=10, branch asserted.
REQ-007 SHALL decode ALUControl from Funct[4:1] only in EXECR, EXECI, LONGWAIT: 0100 add=0, 0010 sub=1, 0000 and=2, 1100 orr=3, 0001 mul=4, 1001 umul=5, 1010 smul=6, 1000 div=7, 1101 mov=8; else ALUControl=0.
REQ-008 SHALL treat mul, umul, smul, div as long-ops.
REQ-009 SHALL assert LongStart exactly on the first LONGWAIT cycle.
REQ-010 SHALL hold ALUControl stable throughout LONGWAIT.
REQ-011 SHALL exit LONGWAIT on LongDone=1: umul/smul->WB2 via ALUWB (RegW then RegW2); mul/div->ALUWB.
REQ-012 SHALL count LONGWAIT cycles and, on reaching LONG_TIMEOUT without LongDone, pulse Fault and return to FETCH with no register write.
REQ-013 SHALL give LongDone priority when it coincides with timeout.
REQ-014 SHALL set FlagW[1]=Funct[0], FlagW[0]=Funct[0]&(add|sub), only in the ALU-execute cycle (EXECR, EXECI, or LONGWAIT exit cycle); 00 elsewhere.
REQ-015 SHALL assert PCS=((Rd==1111)&RegW)|branch.
REQ-016 SHALL drive ImmSrc=Op, RegSrc[0]=(Op==10), RegSrc[1]=(Op==01), combinationally.

Reset
REQ-017 SHALL on reset enter FETCH asynchronously, clear timeout counter, Fault=0, LongStart=0.
REQ-018 SHALL abandon any LONGWAIT on reset mid-operation without a LongStart re-pulse until re-entry.

Configuration
REQ-019 SHALL, with DECODE_FP_EN defined, decode Funct[4:1] 1110 fadd and 1111 fmul as ALUControl 9 and 10 with Half=0, and 0110 faddh and 0111 fmulh as 9 and 10 with Half=1, all as long-ops.
REQ-020 SHALL, without DECODE_FP_EN, treat those four codes as undefined (Fault, ->FETCH) and tie Half=0.

Structure
REQ-021 SHALL place state enum, ALUControl code constants and Funct code constants in shared package decode_pkg.
REQ-022 SHALL isolate the FSM and timeout counter in sub-module decode_fsm; ALU decode and PC logic stay in decode_ctrl.

Verification
REQ-023 SHALL cover: reset, then Op=00 Funct=101000 (add imm, S=0) -> FETCH,DECODE,EXECI,ALUWB; ALUControl=0 in EXECI, RegW=1 in ALUWB, FlagW=00.
REQ-024 SHALL cover: Op=01 Funct=000001 (LDR) -> MEMRD then MEMWB with RegW=1; Rd=1111 -> PCS=1 in MEMWB.
REQ-025 SHALL cover: Op=00 Funct=010011 (umul, S=1), LongDone after 5 cycles -> one LongStart pulse, FlagW=10 on exit cycle, RegW then RegW2.
REQ-026 SHALL cover: div with LongDone held 0 -> Fault pulse after exactly 64 LONGWAIT cycles, no RegW, back to FETCH; LongDone coinciding with cycle 64 -> no Fault.
REQ-027 SHALL cover: Funct[4:1]=0110 -> with DECODE_FP_EN ALUControl=9, Half=1; without it Fault=1, ->FETCH.
REQ-028 SHALL cover: reset asserted during LONGWAIT -> FETCH immediately, all outputs at reset values.
